i2c_target_rx: RTL and testbench

- Synthesizable I2C target (slave) receiver; the responding end for the team's I2C write initiator.
- Oversamples SCL and SDA on the system clock and detects START, repeated START and STOP.
- Receives an address byte, ACKs its own 7-bit address on writes, then receives data bytes, ACKs each one and presents it on a byte-wide output with a one-cycle valid strobe.
- Sits between the board-level open-drain SDA pad and the user register logic.

---
 rtl/i2c_target_rx.sv | 193 +++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// I2C target receiver: filters SCL/SDA, detects START/STOP, ACKs its own write address
// and every following data byte, and strobes each received byte out.
module i2c_target_rx #(
    parameter logic [6:0]  DEV_ADDR   = 7'h50,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       ADDR_MATCH,
    output logic       BUSY,
    output logic       START_DET,
    output logic       STOP_DET
);

    typedef enum logic [2:0] {StIdle, StAddr, StAddrAck, StData, StDataAck, StIgnore} state_e;

    localparam logic [3:0] FiltLast = 4'(FILTER_LEN - 1);

    // Bit 0 carries SCL, bit 1 carries SDA.
    logic [1:0]      sync1_q, sync2_q, filt_q, filt_d, prev_q;
    logic [1:0][3:0] fcnt_q, fcnt_d;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FiltLast) begin
                filt_d[i] = sync2_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
            filt_q  <= '1;
            prev_q  <= '1;
            fcnt_q  <= '0;
        end else begin
            sync1_q <= {SDA_IN, SCL_IN};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            fcnt_q  <= fcnt_d;
        end
    end

    logic scl_f, sda_f, scl_p, sda_p;
    logic scl_rise, scl_fall, start_cond, stop_cond;

    assign scl_f      = filt_q[0];
    assign sda_f      = filt_q[1];
    assign scl_p      = prev_q[0];
    assign sda_p      = prev_q[1];
    assign scl_rise   = scl_f & ~scl_p;
    assign scl_fall   = ~scl_f & scl_p;
    // SCL must be steady high, so an SDA change coinciding with an SCL edge stays data.
    assign start_cond = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_cond  = scl_f & scl_p & ~sda_p & sda_f;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d, bit_idx;
    logic [7:0] shreg_q, shreg_d, byte_rx;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       addr_match_q, addr_match_d;
    logic       busy_q, busy_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;

    assign bit_idx = LSB_FIRST ? bit_cnt_q : (3'd7 - bit_cnt_q);

    always_comb begin
        byte_rx          = shreg_q;
        byte_rx[bit_idx] = sda_f;

        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        rx_data_d    = rx_data_q;
        sda_oe_d     = sda_oe_q;
        addr_match_d = addr_match_q;
        busy_d       = busy_q;
        rx_valid_d   = 1'b0;
        start_det_d  = 1'b0;
        stop_det_d   = 1'b0;

        if (stop_cond) begin
            state_d      = StIdle;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
            busy_d       = 1'b0;
            stop_det_d   = 1'b1;
        end else if (start_cond) begin
            state_d      = StAddr;
            bit_cnt_d    = '0;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
            busy_d       = 1'b1;
            start_det_d  = 1'b1;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shreg_d   = byte_rx;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_rx[7:1] == DEV_ADDR && !byte_rx[0]) begin
                                state_d      = StAddrAck;
                                addr_match_d = 1'b1;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StAddrAck, StDataAck: begin
                    // First fall (end of bit 8) grabs SDA, second fall (end of bit 9) frees it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            state_d   = StData;
                            bit_cnt_d = '0;
                        end
                    end
                end
                StData: begin
                    if (scl_rise) begin
                        shreg_d   = byte_rx;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = byte_rx;
                            rx_valid_d = 1'b1;
                            state_d    = StDataAck;
                        end
                    end
                end
                StIdle, StIgnore: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            sda_oe_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            sda_oe_q     <= sda_oe_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
            start_det_q  <= start_det_d;
            stop_det_q   <= stop_det_d;
        end
    end

    assign SDA_OE     = sda_oe_q;
    assign RX_DATA    = rx_data_q;
    assign RX_VALID   = rx_valid_q;
    assign ADDR_MATCH = addr_match_q;
    assign BUSY       = busy_q;
    assign START_DET  = start_det_q;
    assign STOP_DET   = stop_det_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: an LSB-first and an MSB-first target share one open-drain bus
// driven by a bit-level initiator; a byte-level model predicts ACKs and received bytes.
module tb_i2c_target_rx;

    localparam int Q = 10;  // quarter SCL period in clock cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_tb = 1'b1;
    logic       sda_line;
    logic [1:0] sda_oe, rx_valid, addr_match, busy, start_det, stop_det;
    logic [7:0] rx_data [2];

    always #5 clk = ~clk;

    assign sda_line = sda_tb & ~sda_oe[0] & ~sda_oe[1];

    i2c_target_rx #(.DEV_ADDR(7'h50), .LSB_FIRST(1'b1), .FILTER_LEN(3)) u_lsb (
        .CLK(clk), .RST_N(rst_n), .SCL_IN(scl), .SDA_IN(sda_line), .SDA_OE(sda_oe[0]),
        .RX_DATA(rx_data[0]), .RX_VALID(rx_valid[0]), .ADDR_MATCH(addr_match[0]),
        .BUSY(busy[0]), .START_DET(start_det[0]), .STOP_DET(stop_det[0])
    );

    i2c_target_rx #(.DEV_ADDR(7'h50), .LSB_FIRST(1'b0), .FILTER_LEN(3)) u_msb (
        .CLK(clk), .RST_N(rst_n), .SCL_IN(scl), .SDA_IN(sda_line), .SDA_OE(sda_oe[1]),
        .RX_DATA(rx_data[1]), .RX_VALID(rx_valid[1]), .ADDR_MATCH(addr_match[1]),
        .BUSY(busy[1]), .START_DET(start_det[1]), .STOP_DET(stop_det[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed activity, collected away from the active edge.
    logic [7:0] got0 [$];
    logic [7:0] got1 [$];
    int         n_start [2] = '{0, 0};
    int         n_stop  [2] = '{0, 0};
    int         oe_bad  [2] = '{0, 0};
    logic       ack_win = 1'b0;

    always @(negedge clk) begin
        if (rx_valid[0]) got0.push_back(rx_data[0]);
        if (rx_valid[1]) got1.push_back(rx_data[1]);
        for (int k = 0; k < 2; k++) begin
            if (start_det[k]) n_start[k]++;
            if (stop_det[k]) n_stop[k]++;
            if (sda_oe[k] && !ack_win) oe_bad[k]++;
        end
    end

    // Byte-level reference model.
    localparam bit TgtLsb [2] = '{1'b1, 1'b0};
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    bit         m_match [2] = '{1'b0, 1'b0};
    int         e_start = 0;
    int         e_stop = 0;

    // Maps a byte to/from wire order: element i is the i-th bit on the wire.
    function automatic logic [7:0] reorder(input logic [7:0] v, input bit lsb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = lsb ? v[i] : v[7 - i];
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        cyc(Q); sda_tb = 1'b0; cyc(Q); scl = 1'b0;
        e_start++;
        m_match = '{1'b0, 1'b0};
    endtask

    task automatic do_rstart();
        cyc(Q); sda_tb = 1'b1; cyc(Q); scl = 1'b1; cyc(Q); sda_tb = 1'b0; cyc(Q); scl = 1'b0;
        e_start++;
        m_match = '{1'b0, 1'b0};
    endtask

    task automatic do_stop();
        cyc(Q); sda_tb = 1'b0; cyc(Q); scl = 1'b1; cyc(Q); sda_tb = 1'b1; cyc(2 * Q);
        e_stop++;
        m_match = '{1'b0, 1'b0};
    endtask

    task automatic send_bit(input bit b, input bit glitch);
        cyc(Q); sda_tb = b; cyc(Q); scl = 1'b1;
        if (glitch) begin
            cyc(3); scl = 1'b0; cyc(2); scl = 1'b1; cyc(2 * Q - 5);
        end else begin
            cyc(2 * Q);
        end
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] val, input bit lsb_tx, input bit is_addr,
                             input int glitch_bit, input bit rst_in_ack, input string tag);
        logic [7:0] w, seen;
        bit         exp_ack [2];
        w = reorder(val, lsb_tx);
        for (int i = 0; i < 8; i++) send_bit(w[i], i == glitch_bit);
        for (int k = 0; k < 2; k++) begin
            seen = reorder(w, TgtLsb[k]);
            if (is_addr) m_match[k] = (seen[7:1] == 7'h50) && !seen[0];
            else if (m_match[k]) begin
                if (k == 0) exp0.push_back(seen);
                else exp1.push_back(seen);
            end
            exp_ack[k] = m_match[k];
        end
        ack_win = 1'b1;
        cyc(Q); sda_tb = 1'b1; cyc(Q); scl = 1'b1; cyc(Q);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s/ack%0d", tag, k), sda_oe[k], exp_ack[k]);
            chk($sformatf("%s/match%0d", tag, k), addr_match[k], m_match[k]);
            chk($sformatf("%s/busy%0d", tag, k), busy[k], 1'b1);
        end
        if (rst_in_ack) begin
            #1 rst_n = 1'b0;
            #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("%s/rst_oe%0d", tag, k), sda_oe[k], 1'b0);
                chk($sformatf("%s/rst_busy%0d", tag, k), busy[k], 1'b0);
            end
            cyc(3); rst_n = 1'b1; cyc(2 * Q);
            m_match = '{1'b0, 1'b0};
        end else begin
            cyc(Q); scl = 1'b0; cyc(8);
        end
        ack_win = 1'b0;
    endtask

    task automatic check_txn(input string tag);
        chk({tag, "/n_rx0"}, got0.size(), exp0.size());
        for (int i = 0; i < exp0.size() && i < got0.size(); i++)
            chk($sformatf("%s/rx0[%0d]", tag, i), got0[i], exp0[i]);
        chk({tag, "/n_rx1"}, got1.size(), exp1.size());
        for (int i = 0; i < exp1.size() && i < got1.size(); i++)
            chk($sformatf("%s/rx1[%0d]", tag, i), got1[i], exp1[i]);
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s/starts%0d", tag, k), n_start[k], e_start);
            chk($sformatf("%s/stops%0d", tag, k), n_stop[k], e_stop);
            chk($sformatf("%s/oe_outside%0d", tag, k), oe_bad[k], 0);
            chk($sformatf("%s/end_busy%0d", tag, k), busy[k], 1'b0);
            chk($sformatf("%s/end_match%0d", tag, k), addr_match[k], 1'b0);
            chk($sformatf("%s/end_oe%0d", tag, k), sda_oe[k], 1'b0);
        end
    endtask

    bit         r_lsb, r_rw;
    logic [6:0] r_a7;
    int         r_nseg, r_nb;

    initial begin
        cyc(3);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset/oe%0d", k), sda_oe[k], 1'b0);
            chk($sformatf("reset/data%0d", k), rx_data[k], 8'h00);
            chk($sformatf("reset/valid%0d", k), rx_valid[k], 1'b0);
            chk($sformatf("reset/match%0d", k), addr_match[k], 1'b0);
            chk($sformatf("reset/busy%0d", k), busy[k], 1'b0);
            chk($sformatf("reset/det%0d", k), {start_det[k], stop_det[k]}, 2'b00);
        end
        rst_n = 1'b1;
        cyc(5);

        do_start(); send_byte(8'hA0, 1'b1, 1'b1, -1, 1'b0, "t1a");
        send_byte(8'hA5, 1'b1, 1'b0, -1, 1'b0, "t1d"); do_stop(); check_txn("match_lsb");

        do_start(); send_byte(8'hA2, 1'b1, 1'b1, -1, 1'b0, "t2a");
        send_byte(8'h3C, 1'b1, 1'b0, -1, 1'b0, "t2d"); do_stop(); check_txn("mismatch");

        do_start(); send_byte(8'hA1, 1'b1, 1'b1, -1, 1'b0, "t3a");
        send_byte(8'h77, 1'b1, 1'b0, -1, 1'b0, "t3d"); do_stop(); check_txn("read_req");

        do_start(); send_byte(8'hA0, 1'b0, 1'b1, -1, 1'b0, "t4a");
        send_byte(8'h11, 1'b0, 1'b0, -1, 1'b0, "t4d1");
        send_byte(8'h22, 1'b0, 1'b0, -1, 1'b0, "t4d2");
        do_rstart(); send_byte(8'hA0, 1'b0, 1'b1, -1, 1'b0, "t4b");
        send_byte(8'h33, 1'b0, 1'b0, -1, 1'b0, "t4d3"); do_stop(); check_txn("msb_rstart");

        do_start(); send_byte(8'hA0, 1'b1, 1'b1, -1, 1'b0, "t5a");
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        do_stop(); check_txn("partial_stop");

        do_start(); send_byte(8'hA0, 1'b1, 1'b1, -1, 1'b0, "t6a");
        send_byte(8'h5A, 1'b1, 1'b0, -1, 1'b1, "t6d"); check_txn("reset_in_ack");

        do_start(); send_byte(8'hA0, 1'b1, 1'b1, -1, 1'b0, "t7a");
        send_byte(8'hC3, 1'b1, 1'b0, -1, 1'b0, "t7d"); do_stop(); check_txn("after_reset");

        do_start(); send_byte(8'hA0, 1'b1, 1'b1, -1, 1'b0, "t8a");
        send_byte(8'hA5, 1'b1, 1'b0, 3, 1'b0, "t8d"); do_stop(); check_txn("glitch");

        for (int t = 0; t < 6; t++) begin
            r_lsb = 1'($urandom_range(0, 1));
            r_nseg = 1 + $urandom_range(0, 1);
            do_start();
            for (int s = 0; s < r_nseg; s++) begin
                if (s > 0) do_rstart();
                r_a7 = ($urandom_range(0, 1) == 0) ? 7'h50 : 7'($urandom);
                r_rw = ($urandom_range(0, 3) == 0);
                send_byte({r_a7, r_rw}, r_lsb, 1'b1, -1, 1'b0, $sformatf("r%0d_a", t));
                r_nb = 1 + $urandom_range(0, 2);
                for (int b = 0; b < r_nb; b++)
                    send_byte(8'($urandom), r_lsb, 1'b0, -1, 1'b0, $sformatf("r%0d_d%0d", t, b));
            end
            do_stop();
            check_txn($sformatf("random%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
